phase_controller: RTL and testbench

Multi-cycle core sequencer that steps every instruction through the five pipeline phases (fetch, decode, execute, memory, writeback) one phase at a time. It drives the one-hot `phase_*` enables consumed by each stage, holds the current phase while that stage raises its `stall_*`, and reports retirement. It also maintains the instruction-retired and active-cycle counters. It sits at core top level between the stage modules and the run/halt control.

---
 rtl/phase_controller.sv | 96 +++++++++
 tb/tb_phase_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/phase_controller.sv
// Five-phase multi-cycle sequencer with per-stage stall hold,
// retire strobe, and instret/cycle counters.
module phase_controller #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            cnt_clr,
    input  logic            stall_fetch,
    input  logic            stall_decode,
    input  logic            stall_execute,
    input  logic            stall_memory,
    input  logic            stall_writeback,
    output logic            phase_fetch,
    output logic            phase_decode,
    output logic            phase_execute,
    output logic            phase_memory,
    output logic            phase_writeback,
    output logic            retire,
    output logic            halted,
    output logic [XLEN-1:0] instret,
    output logic [XLEN-1:0] cycle
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] instret_q, instret_d;
    logic [XLEN-1:0] cycle_q, cycle_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            instret_q <= '0;
            cycle_q   <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
            cycle_q   <= cycle_d;
        end
    end

    // Only the active phase's stall is consulted; run only at boundaries.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:      state_d = run ? S_FETCH : S_IDLE;
            S_FETCH:     if (!stall_fetch) state_d = S_DECODE;
            S_DECODE:    if (!stall_decode) state_d = S_EXECUTE;
            S_EXECUTE:   if (!stall_execute) state_d = S_MEMORY;
            S_MEMORY:    if (!stall_memory) state_d = S_WRITEBACK;
            S_WRITEBACK: begin
                if (!stall_writeback)
                    state_d = run ? S_FETCH : S_IDLE;
            end
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        phase_fetch     = (state_q == S_FETCH);
        phase_decode    = (state_q == S_DECODE);
        phase_execute   = (state_q == S_EXECUTE);
        phase_memory    = (state_q == S_MEMORY);
        phase_writeback = (state_q == S_WRITEBACK);
        halted          = (state_q == S_IDLE);
        retire          = phase_writeback & ~stall_writeback;
    end

    // Clear wins over a coincident increment.
    always_comb begin
        instret_d = instret_q;
        cycle_d   = cycle_q;
        if (cnt_clr) begin
            instret_d = '0;
            cycle_d   = '0;
        end else begin
            if (retire)
                instret_d = instret_q + 1'b1;
            if (state_q != S_IDLE)
                cycle_d = cycle_q + 1'b1;
        end
    end

    assign instret = instret_q;
    assign cycle   = cycle_q;

endmodule

// File: tb/tb_phase_controller.sv
// Directed plus randomized bench for phase_controller against
// a phase-index reference model.
module tb_phase_controller;

    localparam int XW = 8;

    logic          clk;
    logic          rst_n;
    logic          run;
    logic          cnt_clr;
    logic [4:0]    st;
    logic          phase_fetch;
    logic          phase_decode;
    logic          phase_execute;
    logic          phase_memory;
    logic          phase_writeback;
    logic          retire;
    logic          halted;
    logic [XW-1:0] instret;
    logic [XW-1:0] cycle;

    int checks;
    int errors;

    // Model: 0 = idle, 1..5 = F,D,E,M,W
    int            m_ph;
    logic [XW-1:0] m_instret;
    logic [XW-1:0] m_cycle;

    phase_controller #(.XLEN(XW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .run             (run),
        .cnt_clr         (cnt_clr),
        .stall_fetch     (st[0]),
        .stall_decode    (st[1]),
        .stall_execute   (st[2]),
        .stall_memory    (st[3]),
        .stall_writeback (st[4]),
        .phase_fetch     (phase_fetch),
        .phase_decode    (phase_decode),
        .phase_execute   (phase_execute),
        .phase_memory    (phase_memory),
        .phase_writeback (phase_writeback),
        .retire          (retire),
        .halted          (halted),
        .instret         (instret),
        .cycle           (cycle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] exp_phases(input int ph);
        logic [4:0] v;
        v = '0;
        if (ph >= 1 && ph <= 5) v[ph-1] = 1'b1;
        return v;
    endfunction

    function automatic logic exp_retire();
        return (m_ph == 5) && !st[4];
    endfunction

    task automatic check_all();
        chk("phase",
            32'({phase_writeback, phase_memory, phase_execute,
                 phase_decode, phase_fetch}),
            32'(exp_phases(m_ph)));
        chk("retire", 32'(retire), 32'(exp_retire()));
        chk("halted", 32'(halted), 32'(m_ph == 0));
        chk("instret", 32'(instret), 32'(m_instret));
        chk("cycle", 32'(cycle), 32'(m_cycle));
    endtask

    task automatic model_edge();
        logic rt;
        rt = exp_retire();
        if (cnt_clr) begin
            m_instret = '0;
            m_cycle   = '0;
        end else begin
            if (rt) m_instret = m_instret + 1'b1;
            if (m_ph != 0) m_cycle = m_cycle + 1'b1;
        end
        if (m_ph == 0) m_ph = run ? 1 : 0;
        else if (st[m_ph-1]) m_ph = m_ph;
        else if (m_ph < 5) m_ph = m_ph + 1;
        else m_ph = run ? 1 : 0;
    endtask

    // Entered and left at a negedge.
    task automatic cyc(input logic r, input logic c, input logic [4:0] s);
        run = r;
        cnt_clr = c;
        st = s;
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic advance_to(input int p, input logic r);
        int n;
        n = 0;
        while (m_ph != p && n < 40) begin
            cyc(r, 1'b0, 5'b0);
            n++;
        end
        chk("advance_bound", 32'(m_ph), 32'(p));
    endtask

    initial begin
        int n;
        int ex_len;
        int ins_len;
        logic [XW-1:0] snap;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        run = 1'b0;
        cnt_clr = 1'b0;
        st = '0;
        m_ph = 0;
        m_instret = '0;
        m_cycle = '0;
        @(negedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back unstalled instructions
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 5'b0);
        chk("instret_3", 32'(instret), 32'd3);
        chk("cycle_15", 32'(cycle), 32'd15);

        // Execute stalled 3 cycles
        advance_to(1, 1'b1);
        ex_len = 0;
        ins_len = 0;
        n = 0;
        while (n < 30) begin
            logic done;
            done = (m_ph == 5);
            if (m_ph == 3) ex_len++;
            ins_len++;
            cyc(1'b1, 1'b0, (m_ph == 3 && ex_len <= 3) ? 5'b00100 : 5'b0);
            n++;
            if (done) break;
        end
        chk("exec_len", 32'(ex_len), 32'd4);
        chk("instr_len", 32'(ins_len), 32'd8);

        // Inactive-stage stalls ignored during decode
        advance_to(2, 1'b1);
        cyc(1'b1, 1'b0, 5'b11101);
        chk("decode_adv", 32'(phase_execute), 32'd1);

        // Drop run mid-instruction
        advance_to(2, 1'b1);
        advance_to(0, 1'b0);
        snap = cycle;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 5'b0);
        chk("cycle_frozen", 32'(cycle), 32'(snap));
        cyc(1'b1, 1'b0, 5'b0);
        chk("restart_fetch", 32'(phase_fetch), 32'd1);

        // Async reset in MEMORY
        advance_to(4, 1'b1);
        #2;
        rst_n = 1'b0;
        m_ph = 0;
        m_instret = '0;
        m_cycle = '0;
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 5'b0);

        // Random run/stall/clear traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 9) != 0),
                ($urandom_range(0, 49) == 0),
                5'($urandom) & 5'($urandom));
        end

        // cnt_clr coinciding with retire
        advance_to(5, 1'b1);
        cyc(1'b1, 1'b1, 5'b0);
        chk("clr_instret", 32'(instret), 32'd0);
        chk("clr_cycle", 32'(cycle), 32'd0);

        // instret wrap at 2^XW-1
        n = 0;
        while (m_instret != 8'hFF && n < 3000) begin
            cyc(1'b1, 1'b0, 5'b0);
            n++;
        end
        chk("instret_max", 32'(instret), 32'hFF);
        advance_to(5, 1'b1);
        cyc(1'b1, 1'b0, 5'b0);
        chk("instret_wrap", 32'(instret), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
